// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial slice comparator.
package cmp_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;

    localparam int unsigned SLICE_W = 2;

endpackage

// File: rtl/slice_cmp_cell.sv
// One 2-bit stage of the eq/gt comparison cascade, MSB-first.
module slice_cmp_cell
    import cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] a_s,
    input  logic [SLICE_W-1:0] b_s,
    input  logic               eq_in,
    input  logic               gt_in,
    output logic               eq_out,
    output logic               gt_out
);

    // A lower slice can only decide the result while all higher slices were equal.
    assign gt_out = gt_in | (eq_in & (a_s > b_s));
    assign eq_out = eq_in & (a_s == b_s);

endmodule

// File: rtl/serial_slice_cmp.sv
// Sequential unsigned comparator: walks operands MSB-first one 2-bit slice per clock,
// exits early on the first differing slice, and reports registered EQ/GT with a done pulse.
module serial_slice_cmp
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             EQ,
    output logic             GT
);

    localparam int unsigned S       = WIDTH / SLICE_W;
    localparam int unsigned IDX_W   = (S > 1) ? $clog2(S) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(S - 1);

    cmp_state_t         state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               eq_acc_q;
    logic               gt_acc_q;
    logic               done_q;
    logic               eq_q;
    logic               gt_q;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic               eq_acc_d;
    logic               gt_acc_d;

    assign a_slice = a_q[SLICE_W*idx_q +: SLICE_W];
    assign b_slice = b_q[SLICE_W*idx_q +: SLICE_W];

    slice_cmp_cell u_cell (
        .a_s    (a_slice),
        .b_s    (b_slice),
        .eq_in  (eq_acc_q),
        .gt_in  (gt_acc_q),
        .eq_out (eq_acc_d),
        .gt_out (gt_acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= IDX_TOP;
            a_q      <= '0;
            b_q      <= '0;
            eq_acc_q <= 1'b1;
            gt_acc_q <= 1'b0;
            done_q   <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        eq_acc_q <= 1'b1;
                        gt_acc_q <= 1'b0;
                        idx_q    <= IDX_TOP;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    eq_acc_q <= eq_acc_d;
                    gt_acc_q <= gt_acc_d;
                    // Exit is decided before the decrement so idx never wraps.
                    if (!eq_acc_d || (idx_q == '0)) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    eq_q    <= eq_acc_q;
                    gt_q    <= gt_acc_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign EQ   = eq_q;
    assign GT   = gt_q;

endmodule

// File: tb/tb_serial_slice_cmp.sv
// Scoreboard bench: drivers push expected results from an arithmetic model, monitors pop on done.
module tb_serial_slice_cmp;

    typedef struct {
        logic eq;
        logic gt;
        int   lat;
        int   acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    bit         in_reset = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, eq8, gt8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, eq4, gt4;

    exp_t       q8[$];
    exp_t       q4[$];
    logic       hold_eq8 = 1'b0;
    logic       hold_gt8 = 1'b0;
    int         busy_cnt8 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_slice_cmp #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .EQ    (eq8),
        .GT    (gt8)
    );

    serial_slice_cmp #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .EQ    (eq4),
        .GT    (gt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Number of slices examined: up to and including the first differing slice from the top.
    function automatic int slices_examined(input int unsigned av, input int unsigned bv,
                                           input int s);
        for (int i = s - 1; i >= 0; i--) begin
            if (((av >> (2 * i)) & 3) != ((bv >> (2 * i)) & 3)) return s - i;
        end
        return s;
    endfunction

    // mode 0: no extra starts, 1: random extra starts while busy, 2: start every busy cycle.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input int mode);
        exp_t e;
        @(negedge clk);
        e.eq  = (av == bv);
        e.gt  = (av > bv);
        e.lat = slices_examined(av, bv, 4) + 1;
        e.acc = cyc + 1;
        q8.push_back(e);
        start8 = 1'b1;
        a8     = av;
        b8     = bv;
        @(negedge clk);
        while (cyc < e.acc + e.lat) begin
            start8 = (mode == 2) || ((mode == 1) && ($urandom_range(0, 1) == 1));
            a8     = (mode == 2) ? 8'hFF : 8'($urandom);
            b8     = (mode == 2) ? 8'h00 : 8'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
    endtask

    task automatic run4(input logic [3:0] av, input logic [3:0] bv);
        exp_t e;
        @(negedge clk);
        e.eq  = (av == bv);
        e.gt  = (av > bv);
        e.lat = slices_examined(av, bv, 2) + 1;
        e.acc = cyc + 1;
        q4.push_back(e);
        start4 = 1'b1;
        a4     = av;
        b4     = bv;
        @(negedge clk);
        start4 = 1'b0;
        while (cyc < e.acc + e.lat) @(negedge clk);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (in_reset) begin
            q8.delete();
            hold_eq8  = 1'b0;
            hold_gt8  = 1'b0;
            busy_cnt8 = 0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                check("done8_unexpected", 32'(done8), 32'd0);
            end else begin
                e = q8.pop_front();
                check("eq8", 32'(eq8), 32'(e.eq));
                check("gt8", 32'(gt8), 32'(e.gt));
                check("lat8", 32'(cyc - e.acc), 32'(e.lat));
                check("busy_cycles8", 32'(busy_cnt8), 32'(e.lat));
                hold_eq8 = e.eq;
                hold_gt8 = e.gt;
            end
            check("busy8_at_done", 32'(busy8), 32'd0);
            busy_cnt8 = 0;
        end else begin
            check("hold_eq8", 32'(eq8), 32'(hold_eq8));
            check("hold_gt8", 32'(gt8), 32'(hold_gt8));
            if (busy8) busy_cnt8++;
        end
    end

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (in_reset) begin
            q4.delete();
        end else if (done4) begin
            if (q4.size() == 0) begin
                check("done4_unexpected", 32'(done4), 32'd0);
            end else begin
                e = q4.pop_front();
                check("eq4", 32'(eq4), 32'(e.eq));
                check("gt4", 32'(gt4), 32'(e.gt));
                check("lat4", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        logic [7:0] av;
        logic [7:0] bv;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_eq8", 32'(eq8), 32'd0);
        check("rst_gt8", 32'(gt8), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        in_reset = 1'b0;

        run8(8'hA5, 8'hA5, 0);
        run8(8'hC0, 8'h80, 0);
        run8(8'h12, 8'h13, 0);
        run8(8'h01, 8'h00, 2);
        repeat (3) @(negedge clk);

        // Abort a compare mid-run; no done may follow.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h55;
        b8     = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        in_reset = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy8", 32'(busy8), 32'd0);
        check("abort_done8", 32'(done8), 32'd0);
        check("abort_eq8", 32'(eq8), 32'd0);
        check("abort_gt8", 32'(gt8), 32'd0);
        in_reset = 1'b0;
        repeat (6) @(negedge clk);

        run8(8'h40, 8'h80, 0);

        for (int n = 0; n < 150; n++) begin
            av = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       bv = av;
                1:       bv = av ^ (8'd1 << $urandom_range(0, 7));
                default: bv = 8'($urandom);
            endcase
            run8(av, bv, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run4(4'(i), 4'(j));
            end
        end

        repeat (8) @(negedge clk);
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
